// File: rtl/cache_sdpram_fwd.sv
// cache_sdpram_fwd: byte-masked simple dual-port cache RAM with 1/2-cycle read latency,
// write-to-read forwarding and a clear-on-reset sweep.
module cache_sdpram_fwd #(
  parameter int portWidth = 256,
  parameter int byteWidth = 8,
  parameter int ramDepth = 128,
  parameter int wenWidth = portWidth / byteWidth,
  parameter int readLatency = 1,
  parameter int forwarding = 1,
  parameter int clearOnReset = 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        ena,
  input  logic [$clog2(ramDepth)-1:0] addra,
  input  logic [wenWidth-1:0]         wen,
  input  logic [portWidth-1:0]        wdata,
  input  logic                        enb,
  input  logic [$clog2(ramDepth)-1:0] addrb,
  output logic [portWidth-1:0]        rdata,
  output logic                        rvalid,
  output logic                        init_busy
);
  localparam int AW = $clog2(ramDepth);
  typedef enum logic {INIT, RUN} state_t;
  state_t state;
  logic [AW-1:0] cnt, waddr, a1;
  logic busy_q, run, we, re, v1, v2;
  logic [wenWidth-1:0] wmask, m1;
  logic [portWidth-1:0] mem [ramDepth];
  logic [portWidth-1:0] wd, ram_q, d1, d2, out_q, resp;
  function automatic logic [portWidth-1:0] merge(input logic [portWidth-1:0] base,
                                                 input logic [wenWidth-1:0] m,
                                                 input logic [portWidth-1:0] d);
    merge = base;
    for (int i = 0; i < wenWidth; i++)
      if (m[i]) merge[i*byteWidth +: byteWidth] = d[i*byteWidth +: byteWidth];
  endfunction
  // the sweep owns the write port while in INIT; nothing touches the array during reset
  always_comb begin
    run = state == RUN;
    we = reset && (!run || ena);
    waddr = run ? addra : cnt;
    wmask = run ? wen : '1;
    wd = run ? wdata : '0;
    re = reset && run && enb;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= (clearOnReset != 0) ? INIT : RUN;
      cnt <= '0;
      busy_q <= clearOnReset != 0;
    end else if (state == INIT) begin
      cnt <= cnt + 1'b1;
      if (cnt == AW'(ramDepth - 1)) begin
        state <= RUN;
        busy_q <= 1'b0;
      end
    end
  end
  always_ff @(posedge clk) begin
    for (int i = 0; i < wenWidth; i++)
      if (we && wmask[i]) mem[waddr][i*byteWidth +: byteWidth] <= wd[i*byteWidth +: byteWidth];
    if (re) ram_q <= mem[addrb];
  end
  // ram_q is read-first; bytes written at or after the request edge are overlaid from m1/d1 and stage 2
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      a1 <= '0;
      m1 <= '0;
      d1 <= '0;
      d2 <= '0;
      out_q <= '0;
    end else begin
      v1 <= re;
      v2 <= v1;
      if (re) begin
        a1 <= addrb;
        m1 <= (forwarding != 0 && ena && addra == addrb) ? wen : '0;
        d1 <= wdata;
      end
      if (v1) d2 <= merge(merge(ram_q, m1, d1), (forwarding != 0 && ena && addra == a1) ? wen : '0, wdata);
      if (rvalid) out_q <= rdata;
    end
  end
  always_comb begin
    rvalid = (readLatency == 2) ? v2 : v1;
    resp = (readLatency == 2) ? d2 : merge(ram_q, m1, d1);
    rdata = rvalid ? resp : out_q;
    init_busy = busy_q;
  end
endmodule

// File: tb/tb_cache_sdpram_fwd.sv
// tb_cache_sdpram_fwd: scoreboard bench driving three configurations (L1 fwd, L2 fwd, L1 read-first) in lockstep.
module tb_cache_sdpram_fwd;
  typedef struct {logic [255:0] d; int due;} exp_t;
  logic clk = 0, reset, ena, enb, chk;
  logic [6:0] addra, addrb;
  logic [31:0] wen;
  logic [255:0] wdata;
  logic [255:0] rd_o [3];
  logic rv [3], busy [3];
  exp_t q [3][$];
  int total = 0, bad = 0, cyc = 0;
  localparam logic [255:0] Z = '0;
  localparam logic [255:0] A5 = {32{8'hA5}};
  localparam logic [255:0] BM = {{31{8'h11}}, 8'hFF};
  localparam logic [255:0] CC = {{30{8'h00}}, 16'hCCCC};
  localparam logic [255:0] X5A = {32{8'h5A}};
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  cache_sdpram_fwd #(.readLatency(1), .forwarding(1)) u0 (.clk(clk), .reset(reset), .ena(ena), .addra(addra),
    .wen(wen), .wdata(wdata), .enb(enb), .addrb(addrb), .rdata(rd_o[0]), .rvalid(rv[0]), .init_busy(busy[0]));
  cache_sdpram_fwd #(.readLatency(2), .forwarding(1)) u1 (.clk(clk), .reset(reset), .ena(ena), .addra(addra),
    .wen(wen), .wdata(wdata), .enb(enb), .addrb(addrb), .rdata(rd_o[1]), .rvalid(rv[1]), .init_busy(busy[1]));
  cache_sdpram_fwd #(.readLatency(1), .forwarding(0)) u2 (.clk(clk), .reset(reset), .ena(ena), .addra(addra),
    .wen(wen), .wdata(wdata), .enb(enb), .addrb(addrb), .rdata(rd_o[2]), .rvalid(rv[2]), .init_busy(busy[2]));
  task automatic check(input string nm, input logic [255:0] got, input logic [255:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, got, want);
    end
  endtask
  always @(negedge clk) begin
    exp_t e;
    if (chk)
      for (int k = 0; k < 3; k++)
        if (rv[k]) begin
          if (q[k].size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_rvalid dut%0d got rdata=%h want no response", k, rd_o[k]);
          end else begin
            e = q[k].pop_front();
            check($sformatf("rdata_dut%0d", k), rd_o[k], e.d);
            check($sformatf("latency_dut%0d", k), 256'(cyc), 256'(e.due));
          end
        end
  end
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic op(input bit w, input logic [6:0] wa, input logic [31:0] m, input logic [255:0] d,
                    input bit r, input logic [6:0] ra, input logic [255:0] e0, e1, e2);
    ena = w; addra = wa; wen = m; wdata = d; enb = r; addrb = ra;
    if (r) begin
      q[0].push_back('{e0, cyc + 1});
      q[1].push_back('{e1, cyc + 2});
      q[2].push_back('{e2, cyc + 1});
    end
    step();
    ena = 0; enb = 0;
  endtask
  task automatic rd3(input logic [6:0] a, input logic [255:0] e);
    op(0, 0, 0, Z, 1, a, e, e, e);
  endtask
  task automatic sweep(input bit poke);
    int n = 0;
    while (busy[0] && n < 300) begin
      ena = poke && n < 100; addra = 0; wen = '1; wdata = '1; enb = poke; addrb = 0;
      step();
      n++;
    end
    ena = 0; enb = 0;
    check("sweep_cycles", 256'(n), 256'd128);
    for (int k = 0; k < 3; k++) check($sformatf("busy_low_dut%0d", k), 256'(busy[k]), Z);
  endtask
  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1);
  end
  initial begin
    reset = 0; ena = 0; enb = 0; addra = 0; addrb = 0; wen = 0; wdata = 0; chk = 1;
    repeat (3) step();
    for (int k = 0; k < 3; k++) begin
      check($sformatf("rst_busy_dut%0d", k), 256'(busy[k]), 256'd1);
      check($sformatf("rst_rdata_dut%0d", k), rd_o[k], Z);
      check($sformatf("rst_rvalid_dut%0d", k), 256'(rv[k]), Z);
    end
    reset = 1;
    sweep(1);
    rd3(7'h7F, Z);
    rd3(7'h00, Z);
    op(1, 5, '1, A5, 0, 0, Z, Z, Z);
    rd3(5, A5);
    repeat (3) step();
    for (int k = 0; k < 3; k++) begin
      check($sformatf("hold_rdata_dut%0d", k), rd_o[k], A5);
      check($sformatf("hold_rvalid_dut%0d", k), 256'(rv[k]), Z);
    end
    op(1, 9, '1, {32{8'h11}}, 0, 0, Z, Z, Z);
    op(1, 9, 32'h1, '1, 0, 0, Z, Z, Z);
    rd3(9, BM);
    op(1, 3, 32'h3, {32{8'hCC}}, 1, 3, CC, CC, Z);
    rd3(3, CC);
    op(0, 0, 0, Z, 1, 7, Z, X5A, Z);
    op(1, 7, '1, X5A, 0, 0, Z, Z, Z);
    rd3(7, X5A);
    rd3(20, Z);
    op(0, 0, 0, Z, 0, 0, Z, Z, Z);
    op(1, 20, '1, X5A, 0, 0, Z, Z, Z);
    rd3(20, X5A);
    rd3(5, A5);
    rd3(9, BM);
    rd3(3, CC);
    repeat (4) step();
    chk = 0;
    enb = 1; addrb = 5;
    repeat (3) step();
    reset = 0; enb = 0;
    #1;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("midrst_busy_dut%0d", k), 256'(busy[k]), 256'd1);
      check($sformatf("midrst_rdata_dut%0d", k), rd_o[k], Z);
      check($sformatf("midrst_rvalid_dut%0d", k), 256'(rv[k]), Z);
      q[k].delete();
    end
    chk = 1;
    step();
    reset = 1;
    sweep(0);
    rd3(5, Z);
    rd3(9, Z);
    repeat (4) step();
    for (int k = 0; k < 3; k++) check($sformatf("drain_dut%0d", k), 256'(q[k].size()), Z);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/cache_sdpram_fwd.md
Name: cache_sdpram_fwd

Overview:
Next-generation simple dual-port cache RAM: one byte-masked write port (A), one read port (B), both on one clock. It adds a configurable read latency of 1 or 2 with a read-valid pipeline, and byte-accurate write-to-read forwarding. It also adds an automatic clear-on-reset sweep, so tag/valid arrays need no software flush. It is the storage primitive under the cache tag, valid and data arrays.

Parameters:
- portWidth, 256, data width of each port in bits; must be a multiple of byteWidth.
- byteWidth, 8, number of bits controlled by one write-enable bit.
- ramDepth, 128, number of entries; power of two, at least 2.
- wenWidth, portWidth/byteWidth, width of the byte-enable bus (derived).
- readLatency, 1, number of cycles from a read request to rdata; legal values are 1 and 2 only.
- forwarding, 1, 1 = new-data forwarding on address collision, 0 = old data is returned.
- clearOnReset, 1, 1 = zero every entry after reset, 0 = no sweep.

Ports:
- clk  in  1  clock; all logic is rising-edge.
- reset  in  1  asynchronous, active-low reset.
- ena  in  1  write request.
- addra  in  $clog2(ramDepth)  write address.
- wen  in  wenWidth  byte write enables.
- wdata  in  portWidth  write data.
- enb  in  1  read request.
- addrb  in  $clog2(ramDepth)  read address.
- rdata  out  portWidth  read data.
- rvalid  out  1  one-cycle pulse: rdata carries the response to a read issued readLatency cycles earlier.
- init_busy  out  1  the clear sweep is in progress; all requests are ignored.

Behaviour:
- FSM states: INIT and RUN.
- While reset is low (asynchronous):
  - state = INIT if clearOnReset = 1, otherwise RUN.
  - Sweep counter = 0.
  - rdata = 0, rvalid = 0, and all read-pipeline valid bits = 0.
  - init_busy = 1 if clearOnReset = 1, otherwise 0.
  - Array contents are not reset asynchronously.
- INIT state:
  - Each cycle, write all-zero to entry cnt (all bytes), then increment cnt.
  - After entry ramDepth-1 is written, go to RUN on the next edge.
  - init_busy stays high for exactly ramDepth cycles after reset deasserts.
  - ena and enb are ignored: no array write, no rvalid.
- RUN state, write: when ena = 1, each byte i with wen[i] = 1 takes wdata byte i at the edge. Other bytes are unchanged. ena = 1 with wen = 0 is a no-op.
- RUN state, read:
  - enb = 1 at edge t samples addrb.
  - rdata is updated and rvalid = 1 after edge t+readLatency-1, i.e. visible in the cycle following that edge.
  - With readLatency = 1, the response is visible one cycle after the request.
  - Back-to-back reads are allowed every cycle; the read port is fully pipelined.
  - When no response is due, rvalid = 0 and rdata holds its last value.
- Collision handling (same address, RUN state only):
  - forwarding = 1: any write to the read address at the read's request edge, or at any edge before its response is visible (the request edge plus readLatency-1 later edges), is merged byte-wise into the response. Write-enabled bytes take the newest write data; other bytes keep the array or earlier-merged value.
  - forwarding = 0: the response is the array content before any of those writes (read-first).
- Data is never lost: if a read and a write target the same address, both complete.
- Address width is exact $clog2(ramDepth); there is no wrap or out-of-range case.
- Reset asserted mid-operation:
  - In-flight reads are discarded, with no rvalid.
  - Any write at the same edge as reset deassertion is dropped.
  - The sweep restarts at entry 0 when clearOnReset = 1.
- The array must infer block RAM. Forwarding and merge logic sits beside the RAM in registers, not inside the array.

Test Plan:
- Clear sweep: ramDepth = 128, clearOnReset = 1; release reset.
  - init_busy stays high 128 cycles then drops.
  - A read of address 0x7F then returns 0.
  - A write issued during INIT has no effect.
- Basic write/read: write 0xA5 repeated to address 5 with all wen set, then read address 5 with readLatency = 1.
  - rvalid pulses 1 cycle after the request with rdata = all 0xA5.
  - Repeat with readLatency = 2: rvalid pulses 2 cycles after the request.
- Byte mask: address 9 holds all-0x11; write all-0xFF with wen = 0x0000_0001.
  - A read of address 9 gives byte 0 = 0xFF and all other bytes = 0x11.
- Same-cycle collision: address 3 holds 0; in the same cycle, write 0xCC with wen = 0x3 and read address 3.
  - forwarding = 1: bytes 0-1 = 0xCC, other bytes = 0x00.
  - forwarding = 0: all bytes = 0x00.
  - A follow-up read in both cases shows bytes 0-1 = 0xCC.
- Latency-2 late write: readLatency = 2, forwarding = 1; read address 7 at cycle t, then write 0x5A to address 7 with wen = all at t+1.
  - The response at t+2 = all 0x5A.
- Mid-read reset: issue reads on 3 consecutive cycles, then pulse reset low for 1 cycle.
  - No rvalid appears after reset.
  - init_busy asserts immediately.
  - rdata = 0 during reset.
